// File: rtl/mul8_seq_ctrl_if.sv
// Operand/product handshake bundle for mul8_seq_ctrl.
// master = requester/consumer side, slave = controller side.
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply sequencer driving an external 4x4 core, one nibble pair per step.
// Optional MUL8_SEQ_ZERO_SKIP_EN: a zero operand bypasses the steps and returns 0 after one cycle.
module mul8_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mul8_seq_ctrl_if.slave     bus,
  output logic               busy,
  output logic [3:0]         mul_a,
  output logic [3:0]         mul_b,
  input  logic [7:0]         mul_r
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic LAST_WAIT = (MUL_LAT != 0);

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  localparam logic ZERO_SKIP = 1'b1;
`else
  localparam logic ZERO_SKIP = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        wait_q, wait_d;
  logic        load_q, load_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  mul_a_q, mul_a_d;
  logic [3:0]  mul_b_q, mul_b_d;
  logic [15:0] partial;
  logic        zero_op;

  function automatic logic [3:0] nib(input logic [7:0] v, input logic hi);
    return hi ? v[7:4] : v[3:0];
  endfunction

  assign zero_op = (bus.a == 8'd0) || (bus.b == 8'd0);

  // Partial product weight: step bit0 selects a's high nibble, bit1 selects b's high nibble.
  always_comb begin
    partial = 16'd0;
    case (step_q)
      2'd0:    partial = {8'd0, mul_r};
      2'd1:    partial = {4'd0, mul_r, 4'd0};
      2'd2:    partial = {4'd0, mul_r, 4'd0};
      default: partial = {mul_r, 8'd0};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    load_d      = load_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    mul_a_d     = 4'd0;
    mul_b_d     = 4'd0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.a;
          b_d    = bus.b;
          acc_d  = 16'd0;
          step_d = 2'd0;
          wait_d = 1'b0;
          load_d = 1'b1;
          if (ZERO_SKIP && zero_op) begin
            state_d   = DONE;
            product_d = 16'd0;
          end else begin
            state_d = STEP;
          end
        end
      end

      // The first STEP cycle only loads the core operand registers; each step then
      // holds its nibbles for MUL_LAT+1 cycles and accumulates on the last one.
      STEP: begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (load_q) begin
          load_d  = 1'b0;
          mul_a_d = nib(a_q, step_q[0]);
          mul_b_d = nib(b_q, step_q[1]);
        end else if (wait_q != LAST_WAIT) begin
          wait_d = 1'b1;
        end else begin
          wait_d = 1'b0;
          acc_d  = acc_q + partial;
          if (step_q == 2'd3) begin
            product_d   = acc_d;
            out_valid_d = 1'b1;
            state_d     = DONE;
            mul_a_d     = 4'd0;
            mul_b_d     = 4'd0;
          end else begin
            step_d  = step_q + 2'd1;
            mul_a_d = nib(a_q, step_d[0]);
            mul_b_d = nib(b_q, step_d[1]);
          end
        end
      end

      // out_valid is still low here only on the zero-skip path.
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      wait_q      <= 1'b0;
      load_q      <= 1'b0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      product_q   <= 16'd0;
      out_valid_q <= 1'b0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      load_q      <= load_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign busy          = (state_q != IDLE);
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl: a combinational-core instance (MUL_LAT=0) and a
// registered-core instance (MUL_LAT=1), each with its own behavioural 4x4 core.
module tb_mul8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  mul8_seq_ctrl_if bus0 ();
  mul8_seq_ctrl_if bus1 ();

  logic       busy0, busy1;
  logic [3:0] mul_a0, mul_b0, mul_a1, mul_b1;
  logic [7:0] mul_r0, mul_r1;

  int checks_total  = 0;
  int checks_passed = 0;

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  // External 4x4 cores: instance 0 combinational, instance 1 registered.
  assign mul_r0 = {4'd0, mul_a0} * {4'd0, mul_b0};
  always @(posedge clk) mul_r1 <= {4'd0, mul_a1} * {4'd0, mul_b1};

  mul8_seq_ctrl #(.MUL_LAT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0),
    .busy  (busy0),
    .mul_a (mul_a0),
    .mul_b (mul_b0),
    .mul_r (mul_r0)
  );

  mul8_seq_ctrl #(.MUL_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .busy  (busy1),
    .mul_a (mul_a1),
    .mul_b (mul_b1),
    .mul_r (mul_r1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance 0: waits for in_ready, accepts, counts edges until out_valid.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output int lat, output logic [15:0] prod);
    int guard;
    guard = 0;
    while (!bus0.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    bus0.a        = a;
    bus0.b        = b;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    prod = bus0.product;
  endtask

  initial begin
    int          lat;
    logic [15:0] prod;
    logic [3:0]  seq_a[4];
    logic [3:0]  seq_b[4];
    logic        saw_valid;
    int          guard;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, prod: 16'hFE01, lat: 5};
    vecs[1] = '{a: 8'h12, b: 8'h34, prod: 16'h03A8, lat: 5};
    vecs[2] = '{a: 8'h0F, b: 8'hF0, prod: 16'h0E10, lat: 5};
    vecs[3] = '{a: 8'h03, b: 8'h05, prod: 16'h000F, lat: 5};
    vecs[4] = '{a: 8'hAB, b: 8'hCD, prod: 16'h88EF, lat: 5};
    vecs[5] = '{a: 8'h00, b: 8'h55, prod: 16'h0000, lat: ZLAT};
    vecs[6] = '{a: 8'h80, b: 8'h02, prod: 16'h0100, lat: 5};
    vecs[7] = '{a: 8'h01, b: 8'hC7, prod: 16'h00C7, lat: 5};

    seq_a = '{4'h2, 4'h1, 4'h2, 4'h1};
    seq_b = '{4'h4, 4'h4, 4'h3, 4'h3};

    rst_n          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.a         = 8'd0;
    bus0.b         = 8'd0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 8'd0;
    bus1.b         = 8'd0;
    bus1.out_ready = 1'b1;
    repeat (3) tick();

    checkOutput("reset in_ready", bus0.in_ready, 1);
    checkOutput("reset out_valid", bus0.out_valid, 0);
    checkOutput("reset busy", busy0, 0);
    checkOutput("reset product", bus0.product, 0);
    checkOutput("reset mul_a", mul_a0, 0);
    checkOutput("reset mul_b", mul_b0, 0);
    rst_n = 1'b1;
    tick();

    // Nibble issue order for 0x12 * 0x34.
    bus0.a        = 8'h12;
    bus0.b        = 8'h34;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    checkOutput("seq busy", busy0, 1);
    checkOutput("seq in_ready low", bus0.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("seq mul_a step%0d", i), mul_a0, seq_a[i]);
      checkOutput($sformatf("seq mul_b step%0d", i), mul_b0, seq_b[i]);
    end
    tick();
    checkOutput("seq out_valid", bus0.out_valid, 1);
    checkOutput("seq product", bus0.product, 16'h03A8);
    checkOutput("seq mul_a idle", mul_a0, 0);
    tick();

    // Backpressure with an ignored in_valid while DONE.
    bus0.out_ready = 1'b0;
    bus0.a         = 8'h0F;
    bus0.b         = 8'hF0;
    bus0.in_valid  = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    guard = 0;
    while (!bus0.out_valid && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("bp latency", guard, 5);
    for (int i = 0; i < 3; i++) begin
      bus0.a        = 8'h01;
      bus0.b        = 8'h01;
      bus0.in_valid = 1'b1;
      tick();
      checkOutput($sformatf("bp out_valid %0d", i), bus0.out_valid, 1);
      checkOutput($sformatf("bp product %0d", i), bus0.product, 16'h0E10);
      checkOutput($sformatf("bp in_ready %0d", i), bus0.in_ready, 0);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    checkOutput("bp release out_valid", bus0.out_valid, 0);
    checkOutput("bp release in_ready", bus0.in_ready, 1);
    checkOutput("bp product held", bus0.product, 16'h0E10);
    tick();
    checkOutput("bp no new op", busy0, 0);

    // Table of operand pairs on the combinational-core instance.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat, prod);
      checkOutput($sformatf("vec%0d product", i), prod, vecs[i].prod);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      tick();
      checkOutput($sformatf("vec%0d out_valid one cycle", i), bus0.out_valid, 0);
      checkOutput($sformatf("vec%0d in_ready back", i), bus0.in_ready, 1);
    end

    // Reset while step2 of 0xAB * 0xCD is on the core.
    bus0.a        = 8'hAB;
    bus0.b        = 8'hCD;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("rst step2 mul_a", mul_a0, 4'hB);
    checkOutput("rst step2 mul_b", mul_b0, 4'hC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst in_ready", bus0.in_ready, 1);
    checkOutput("rst out_valid", bus0.out_valid, 0);
    checkOutput("rst busy", busy0, 0);
    checkOutput("rst product", bus0.product, 0);
    checkOutput("rst mul_a", mul_a0, 0);
    checkOutput("rst mul_b", mul_b0, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.out_valid) saw_valid = 1'b1;
    end
    checkOutput("rst no product emitted", saw_valid, 0);
    applyStimulus(8'h03, 8'h05, lat, prod);
    checkOutput("post-rst product", prod, 16'h000F);
    checkOutput("post-rst latency", lat, 5);
    tick();

    // Registered core instance.
    bus1.a        = 8'hAB;
    bus1.b        = 8'hCD;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("lat1 latency", lat, 9);
    checkOutput("lat1 product", bus1.product, 16'h88EF);
    tick();
    checkOutput("lat1 in_ready back", bus1.in_ready, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
